// File: rtl/byte_mem_pkg.sv
// Shared types and helpers for the byte SRAM arbiter: width defaults,
// arbitration state encoding and the round-robin pick function.
package byte_mem_pkg;

    localparam int AW_DEF = 17;
    localparam int DW_DEF = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // One-hot pick of the first set request at or after ptr, wrapping at n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] k;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                k = 3'((int'(ptr) + i) % n);
                if (!found && req[k]) begin
                    rr_pick[k] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/byte_mem_arb_rr_arb_core.sv
// Plain round-robin arbiter: combinational one-hot pick plus the rotating
// priority pointer, which advances past the winner on every grant it issues.
module rr_arb_core
    import byte_mem_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] ptr;
    logic [7:0]    pick;

    always_comb begin
        pick = '0;
        gnt  = '0;
        idx  = '0;
        if (en) begin
            pick = rr_pick(8'(req), 3'(ptr), NREQ);
            gnt  = NREQ'(pick);
            for (int k = 0; k < NREQ; k++) begin
                if (gnt[k]) idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/byte_mem_arb.sv
// Shares one single-port byte SRAM among NREQ requesters: round-robin grant,
// optional burst lock bounded by LOCK_MAX, registered SRAM controls, read-return strobes.
module byte_mem_arb
    import byte_mem_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    lock_i,
    input  logic [NREQ-1:0]    wr_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_di,
    output logic               mem_en,
    output logic               mem_wr,
    input  logic [DW-1:0]      mem_do
);

    localparam int         IW      = $clog2(NREQ);
    localparam logic [7:0] CNT_MAX = 8'(LOCK_MAX);

    arb_state_t      state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [7:0]      lock_cnt, cnt_nxt;
    logic [NREQ-1:0] owner_oh, arb_req, arb_gnt;
    logic [IW-1:0]   arb_idx, sel;
    logic            arb_en, others;
    logic            vld_p1;
    logic [IW-1:0]   id_p1;

    assign owner_oh = NREQ'(1) << owner;
    assign others   = |(req_i & ~owner_oh);

    rr_arb_core #(.NREQ(NREQ), .IW(IW)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     (arb_req),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = lock_cnt;
        arb_en    = 1'b1;
        arb_req   = req_i;
        gnt_o     = '0;
        sel       = '0;
        if (state == LOCKED && req_i[owner] && !(lock_cnt >= CNT_MAX && others)) begin
            arb_en  = 1'b0;
            gnt_o   = owner_oh;
            sel     = owner;
            cnt_nxt = (lock_cnt >= CNT_MAX) ? CNT_MAX : lock_cnt + 8'd1;
            if (!lock_i[owner]) state_nxt = ARB;
        end else begin
            // Starved-out owner sits out exactly this arbitration round.
            if (state == LOCKED && req_i[owner]) arb_req = req_i & ~owner_oh;
            state_nxt = ARB;
            cnt_nxt   = '0;
            gnt_o     = arb_gnt;
            sel       = arb_idx;
            if (|arb_gnt && lock_i[arb_idx]) begin
                state_nxt = LOCKED;
                owner_nxt = arb_idx;
                cnt_nxt   = 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    // p0 -> p1: accepted access drives the SRAM port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_di   <= '0;
            vld_p1   <= 1'b0;
            id_p1    <= '0;
        end else begin
            mem_en <= |gnt_o;
            mem_wr <= |gnt_o & wr_i[sel];
            vld_p1 <= |gnt_o & ~wr_i[sel];
            id_p1  <= sel;
            if (|gnt_o) begin
                mem_addr <= addr_i[sel*AW +: AW];
                mem_di   <= wdata_i[sel*DW +: DW];
            end
        end
    end

    // p1 -> p2: SRAM read data is on mem_do, flag its owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_o <= '0;
        end else begin
            rvalid_o <= vld_p1 ? (NREQ'(1) << id_p1) : '0;
        end
    end

    assign rdata_o = mem_do;

endmodule
